pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86-64 core. It sits beside the F/D/E/M/W pipeline registers and produces their stall and bubble strobes plus the condition-code write enable, using the standard hazard rules: load/use, mispredicted jump, ret, and exception drain. It adds a run-state machine (IDLE/RUN/HALT) that freezes the pipe before start and after an exception retires. It also keeps saturating performance counters.

---
 rtl/pipe_ctrl_if.sv | 54 +++++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the Y86-64 pipeline and pipe_ctrl.
// The pipeline (master) drives stage state; the controller (slave) drives strobes.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [3:0]       m_stat;
  logic [3:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc;
  logic             running;
  logic             halted;
  logic [3:0]       cpu_stat;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic [CNT_W-1:0] ret_cnt;

  modport master (
    output start, D_icode, E_icode, M_icode,
    output d_srcA, d_srcB, E_dstM, e_Cnd,
    output m_stat, W_stat,
    input  F_stall, D_stall, D_bubble,
    input  E_bubble, M_bubble, W_stall,
    input  set_cc, running, halted, cpu_stat,
    input  cycle_cnt, stall_cnt, bubble_cnt,
    input  mispred_cnt, ret_cnt
  );

  modport slave (
    input  start, D_icode, E_icode, M_icode,
    input  d_srcA, d_srcB, E_dstM, e_Cnd,
    input  m_stat, W_stat,
    output F_stall, D_stall, D_bubble,
    output E_bubble, M_bubble, W_stall,
    output set_cc, running, halted, cpu_stat,
    output cycle_cnt, stall_cnt, bubble_cnt,
    output mispred_cnt, ret_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard stall/bubble strobes,
// IDLE/RUN/HALT run state and saturating performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave p
);

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam logic [3:0] S_AOK    = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t state;

  logic exc_m;
  logic exc_w;
  logic loaduse;
  logic mispred;
  logic retp;
  logic run;

  function automatic logic is_exc(
    input logic [3:0] s
  );
    return (s == 4'h2) || (s == 4'h3) ||
           (s == 4'h4);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             en
  );
    if (en && (c != {CNT_W{1'b1}}))
      return c + 1'b1;
    return c;
  endfunction

  // Hazard terms decoded from the current stage contents.
  always_comb begin
    exc_m   = is_exc(p.m_stat);
    exc_w   = is_exc(p.W_stat);
    loaduse = ((p.E_icode == I_MRMOVQ) ||
               (p.E_icode == I_POPQ)) &&
              (p.E_dstM != R_NONE) &&
              ((p.E_dstM == p.d_srcA) ||
               (p.E_dstM == p.d_srcB));
    mispred = (p.E_icode == I_JXX) && !p.e_Cnd;
    retp    = (p.D_icode == I_RET) ||
              (p.E_icode == I_RET) ||
              (p.M_icode == I_RET);
    run     = (state == S_RUN);
  end

  // Pipeline register strobes; frozen outside RUN.
  always_comb begin
    p.F_stall  = 1'b1;
    p.D_stall  = 1'b1;
    p.D_bubble = 1'b0;
    p.E_bubble = 1'b1;
    p.M_bubble = 1'b1;
    p.W_stall  = 1'b1;
    p.set_cc   = 1'b0;
    if (run) begin
      p.F_stall  = loaduse || retp;
      p.D_stall  = loaduse;
      p.D_bubble = mispred ||
                   (retp && !loaduse);
      p.E_bubble = mispred || loaduse;
      p.M_bubble = exc_m || exc_w;
      p.W_stall  = exc_w;
      p.set_cc   = (p.E_icode == I_OPQ) &&
                   !exc_m && !exc_w;
    end
  end

  // Run-state machine with registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      p.running  <= 1'b0;
      p.halted   <= 1'b0;
      p.cpu_stat <= S_AOK;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (p.start) begin
            state     <= S_RUN;
            p.running <= 1'b1;
          end
        end
        S_RUN: begin
          if (exc_w) begin
            state      <= S_HALT;
            p.running  <= 1'b0;
            p.halted   <= 1'b1;
            p.cpu_stat <= p.W_stat;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state     <= S_IDLE;
          p.running <= 1'b0;
          p.halted  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating counters sampled on every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      p.cycle_cnt   <= '0;
      p.stall_cnt   <= '0;
      p.bubble_cnt  <= '0;
      p.mispred_cnt <= '0;
      p.ret_cnt     <= '0;
    end else if (run) begin
      p.cycle_cnt   <= sat_inc(p.cycle_cnt, 1'b1);
      p.stall_cnt   <= sat_inc(p.stall_cnt,
                               p.F_stall);
      p.bubble_cnt  <= sat_inc(p.bubble_cnt,
                               p.D_bubble ||
                               p.E_bubble);
      p.mispred_cnt <= sat_inc(p.mispred_cnt,
                               mispred);
      p.ret_cnt     <= sat_inc(p.ret_cnt,
                               (p.D_icode == I_RET) &&
                               !loaduse);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazards, run state,
// exception drain and counter saturation (4-bit copy).
module tb_pipe_ctrl;

  logic clk;
  logic rst;

  int n_cmp;
  int n_bad;

  pipe_ctrl_if #(.CNT_W(32)) a ();
  pipe_ctrl_if #(.CNT_W(4))  b ();

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .p   (a.slave)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .p   (b.slave)
  );

  assign b.start   = a.start;
  assign b.D_icode = a.D_icode;
  assign b.E_icode = a.E_icode;
  assign b.M_icode = a.M_icode;
  assign b.d_srcA  = a.d_srcA;
  assign b.d_srcB  = a.d_srcB;
  assign b.E_dstM  = a.E_dstM;
  assign b.e_Cnd   = a.e_Cnd;
  assign b.m_stat  = a.m_stat;
  assign b.W_stat  = a.W_stat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a.D_icode = 4'h1;
    a.E_icode = 4'h1;
    a.M_icode = 4'h1;
    a.d_srcA  = 4'hF;
    a.d_srcB  = 4'hF;
    a.E_dstM  = 4'hF;
    a.e_Cnd   = 1'b0;
    a.m_stat  = 4'h1;
    a.W_stat  = 4'h1;
    #1;
  endtask

  task automatic chk_cnt(
    input string tag,
    input int    cyc,
    input int    stl,
    input int    bub,
    input int    mis,
    input int    rt
  );
    chk({tag, ".cyc"}, 64'(a.cycle_cnt), 64'(cyc));
    chk({tag, ".stl"}, 64'(a.stall_cnt), 64'(stl));
    chk({tag, ".bub"}, 64'(a.bubble_cnt), 64'(bub));
    chk({tag, ".mis"}, 64'(a.mispred_cnt), 64'(mis));
    chk({tag, ".ret"}, 64'(a.ret_cnt), 64'(rt));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    a.start = 1'b0;
    idle_in();
    tick();
    rst = 1'b0;
    #1;

    chk("rst.running", 64'(a.running), 64'd0);
    chk("rst.halted", 64'(a.halted), 64'd0);
    chk("rst.stat", 64'(a.cpu_stat), 64'd1);
    chk_cnt("rst", 0, 0, 0, 0, 0);
    chk("idle.F_stall", 64'(a.F_stall), 64'd1);
    chk("idle.D_stall", 64'(a.D_stall), 64'd1);
    chk("idle.D_bubble", 64'(a.D_bubble), 64'd0);
    chk("idle.E_bubble", 64'(a.E_bubble), 64'd1);
    chk("idle.M_bubble", 64'(a.M_bubble), 64'd1);
    chk("idle.W_stall", 64'(a.W_stall), 64'd1);
    chk("idle.set_cc", 64'(a.set_cc), 64'd0);

    // leave IDLE
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    chk("start.running", 64'(a.running), 64'd1);
    chk("start.cyc", 64'(a.cycle_cnt), 64'd0);
    chk("run.ctl",
        64'({a.F_stall, a.D_stall, a.D_bubble,
             a.E_bubble, a.M_bubble, a.W_stall}),
        64'd0);
    repeat (10) tick();
    chk_cnt("run10", 10, 0, 0, 0, 0);

    // load/use
    a.E_icode = 4'h5;
    a.E_dstM  = 4'h3;
    a.d_srcB  = 4'h3;
    a.D_icode = 4'h6;
    #1;
    chk("lu.F_stall", 64'(a.F_stall), 64'd1);
    chk("lu.D_stall", 64'(a.D_stall), 64'd1);
    chk("lu.E_bubble", 64'(a.E_bubble), 64'd1);
    chk("lu.D_bubble", 64'(a.D_bubble), 64'd0);
    tick();
    chk_cnt("lu", 11, 1, 1, 0, 0);
    a.E_dstM = 4'hF;
    a.d_srcA = 4'hF;
    #1;
    chk("nolu.F_stall", 64'(a.F_stall), 64'd0);
    chk("nolu.D_stall", 64'(a.D_stall), 64'd0);
    chk("nolu.E_bubble", 64'(a.E_bubble), 64'd0);
    tick();
    chk_cnt("nolu", 12, 1, 1, 0, 0);

    // mispredicted jump
    idle_in();
    a.E_icode = 4'h7;
    a.e_Cnd   = 1'b0;
    #1;
    chk("mp.D_bubble", 64'(a.D_bubble), 64'd1);
    chk("mp.E_bubble", 64'(a.E_bubble), 64'd1);
    chk("mp.F_stall", 64'(a.F_stall), 64'd0);
    tick();
    chk_cnt("mp", 13, 1, 2, 1, 0);
    a.e_Cnd = 1'b1;
    #1;
    chk("tk.ctl",
        64'({a.F_stall, a.D_stall, a.D_bubble,
             a.E_bubble, a.set_cc}),
        64'd0);
    tick();
    chk_cnt("tk", 14, 1, 2, 1, 0);

    // ret walking D -> E -> M
    idle_in();
    a.D_icode = 4'h9;
    #1;
    chk("retD.F_stall", 64'(a.F_stall), 64'd1);
    chk("retD.D_bubble", 64'(a.D_bubble), 64'd1);
    tick();
    a.D_icode = 4'h1;
    a.E_icode = 4'h9;
    #1;
    chk("retE.F_stall", 64'(a.F_stall), 64'd1);
    chk("retE.D_bubble", 64'(a.D_bubble), 64'd1);
    tick();
    a.E_icode = 4'h1;
    a.M_icode = 4'h9;
    #1;
    chk("retM.F_stall", 64'(a.F_stall), 64'd1);
    chk("retM.D_bubble", 64'(a.D_bubble), 64'd1);
    tick();
    chk_cnt("ret", 17, 4, 5, 1, 1);

    // ret in D while load/use holds D
    a.M_icode = 4'h1;
    a.D_icode = 4'h9;
    a.E_icode = 4'h5;
    a.E_dstM  = 4'h3;
    a.d_srcB  = 4'h3;
    #1;
    chk("retlu.D_stall", 64'(a.D_stall), 64'd1);
    chk("retlu.D_bubble", 64'(a.D_bubble), 64'd0);
    chk("retlu.F_stall", 64'(a.F_stall), 64'd1);
    chk("retlu.E_bubble", 64'(a.E_bubble), 64'd1);
    tick();
    chk_cnt("retlu", 18, 5, 6, 1, 1);

    // exception drain
    idle_in();
    a.E_icode = 4'h6;
    #1;
    chk("opq.set_cc", 64'(a.set_cc), 64'd1);
    a.m_stat = 4'h3;
    #1;
    chk("excm.set_cc", 64'(a.set_cc), 64'd0);
    chk("excm.M_bubble", 64'(a.M_bubble), 64'd1);
    chk("excm.W_stall", 64'(a.W_stall), 64'd0);
    tick();
    a.m_stat = 4'h1;
    a.W_stat = 4'h3;
    #1;
    chk("excw.W_stall", 64'(a.W_stall), 64'd1);
    chk("excw.M_bubble", 64'(a.M_bubble), 64'd1);
    chk("excw.set_cc", 64'(a.set_cc), 64'd0);
    chk("excw.running", 64'(a.running), 64'd1);
    tick();
    chk("halt.halted", 64'(a.halted), 64'd1);
    chk("halt.running", 64'(a.running), 64'd0);
    chk("halt.stat", 64'(a.cpu_stat), 64'd3);
    chk("halt.F_stall", 64'(a.F_stall), 64'd1);
    chk("halt.set_cc", 64'(a.set_cc), 64'd0);
    chk_cnt("halt", 20, 5, 6, 1, 1);

    // frozen in HALT; start is ignored
    a.W_stat  = 4'h1;
    a.E_icode = 4'h7;
    a.e_Cnd   = 1'b0;
    a.start   = 1'b1;
    repeat (5) tick();
    a.start = 1'b0;
    chk("frz.halted", 64'(a.halted), 64'd1);
    chk("frz.D_bubble", 64'(a.D_bubble), 64'd0);
    chk_cnt("frz", 20, 5, 6, 1, 1);
    chk("sat.cyc", 64'(b.cycle_cnt), 64'd15);
    chk("sat.stl", 64'(b.stall_cnt), 64'd5);

    // reset from HALT, start asserted too
    rst     = 1'b1;
    a.start = 1'b1;
    tick();
    rst     = 1'b0;
    a.start = 1'b0;
    #1;
    chk("rh.halted", 64'(a.halted), 64'd0);
    chk("rh.running", 64'(a.running), 64'd0);
    chk("rh.stat", 64'(a.cpu_stat), 64'd1);
    chk_cnt("rh", 0, 0, 0, 0, 0);
    chk("rh.sat.cyc", 64'(b.cycle_cnt), 64'd0);

    // W_stat=5 is not an exception
    idle_in();
    a.start = 1'b1;
    tick();
    a.start  = 1'b0;
    a.W_stat = 4'h5;
    #1;
    chk("w5.W_stall", 64'(a.W_stall), 64'd0);
    tick();
    chk("w5.running", 64'(a.running), 64'd1);
    chk("w5.halted", 64'(a.halted), 64'd0);
    chk("w5.cyc", 64'(a.cycle_cnt), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
